// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: game-state encoding, sprite geometry,
// ghost base score and the mover direction encoding.
// The ghost_score helper converts the eat-chain index into the points
// awarded for one ghost (200, 400, 800, 1600).
package pacman_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    DYING     = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam int          SPRITE_SIZE      = 16;
  localparam logic [11:0] GHOST_BASE_SCORE = 12'd200;

  function automatic logic [11:0] ghost_score(input logic [1:0] chain);
    return GHOST_BASE_SCORE << chain;
  endfunction

endpackage

// File: rtl/sprite_overlap.sv
// Combinational overlap test between Pac-Man and one ghost sprite.
// Ports:
//   pac_x, pac_y  : Pac-Man top-left pixel
//   obj_x, obj_y  : ghost top-left pixel
//   hit           : both per-axis distances are below COLL_DIST
// Distances are taken in 11-bit signed arithmetic so sprites on opposite
// screen edges never appear adjacent through wrap-around.
module sprite_overlap #(
  parameter int COLL_DIST = 12
) (
  input  logic [9:0] pac_x,
  input  logic [9:0] pac_y,
  input  logic [9:0] obj_x,
  input  logic [9:0] obj_y,
  output logic       hit
);

  localparam logic signed [10:0] DIST = 11'(COLL_DIST);

  function automatic logic signed [10:0] abs_diff(input logic [9:0] a,
                                                  input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 11'sd0) ? -d : d;
  endfunction

  assign hit = (abs_diff(pac_x, obj_x) < DIST) && (abs_diff(pac_y, obj_y) < DIST);

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Per-frame ghost collision controller.
// Detects Pac-Man/ghost overlap, runs the power-pellet frightened timer and
// resolves each frame into an eat (score + one ghost respawn), a death
// (freeze, lose a life, later respawn all) or game over.
// Ports:
//   frame_clk, Reset        : frame clock, async active-high reset
//   pac_x, pac_y            : Pac-Man top-left pixel
//   ghost_x, ghost_y        : per-ghost top-left pixels
//   power_pellet            : one-frame pulse, pellet eaten
//   frightened              : per-ghost edible flag
//   fright_warn             : fright timer in its final WARN_FRAMES frames
//   ghost_respawn           : one-frame pulse, drives ghost mover reset
//   score_add               : points to add this frame
//   freeze                  : halts movers during DYING and GAME_OVER
//   lives, game_over        : remaining lives, sticky end-of-game flag
module ghost_collision_ctrl
  import pacman_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int COLL_DIST     = 12,
  parameter int FRIGHT_FRAMES = 360,
  parameter int WARN_FRAMES   = 120,
  parameter int DEATH_FRAMES  = 120,
  parameter int LIVES_INIT    = 3
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [9:0]                 pac_x,
  input  logic [9:0]                 pac_y,
  input  logic [NUM_GHOSTS-1:0][9:0] ghost_x,
  input  logic [NUM_GHOSTS-1:0][9:0] ghost_y,
  input  logic                       power_pellet,
  output logic [NUM_GHOSTS-1:0]      frightened,
  output logic                       fright_warn,
  output logic [NUM_GHOSTS-1:0]      ghost_respawn,
  output logic [11:0]                score_add,
  output logic                       freeze,
  output logic [1:0]                 lives,
  output logic                       game_over
);

  localparam int TW = $clog2(FRIGHT_FRAMES + 1);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  localparam logic [TW-1:0]         FRIGHT_LOAD = TW'(FRIGHT_FRAMES);
  localparam logic [TW-1:0]         WARN_LVL    = TW'(WARN_FRAMES);
  localparam logic [TW-1:0]         TMR_ONE     = TW'(1);
  localparam logic [DW-1:0]         DEATH_LOAD  = DW'(DEATH_FRAMES);
  localparam logic [DW-1:0]         DCNT_ONE    = DW'(1);
  localparam logic [NUM_GHOSTS-1:0] NG_ONE      = NUM_GHOSTS'(1);
  localparam logic [1:0]            LIVES_RST   = 2'(LIVES_INIT);

  state_t          state;
  logic [TW-1:0]   fright_tmr;
  logic [DW-1:0]   death_cnt;
  logic [1:0]      chain;

  logic [NUM_GHOSTS-1:0] overlap;
  logic [NUM_GHOSTS-1:0] fr_eff;
  logic [NUM_GHOSTS-1:0] deadly;
  logic [NUM_GHOSTS-1:0] edible;
  logic [NUM_GHOSTS-1:0] eat_sel;
  logic [NUM_GHOSTS-1:0] fr_nxt;
  logic [TW-1:0]         tmr_dec;
  logic [TW-1:0]         tmr_nxt;
  logic                  warn_nxt;
  logic [1:0]            chain_base;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ovl
    sprite_overlap #(.COLL_DIST(COLL_DIST)) u_ovl (
      .pac_x (pac_x),
      .pac_y (pac_y),
      .obj_x (ghost_x[g]),
      .obj_y (ghost_y[g]),
      .hit   (overlap[g])
    );
  end

  // Next-frame decision terms. A pellet in this frame counts as already
  // applied, so every overlapped ghost is treated as frightened.
  always_comb begin
    fr_eff     = power_pellet ? '1 : frightened;
    deadly     = overlap & ~fr_eff;
    edible     = overlap & fr_eff;
    // Two's-complement trick isolates the lowest edible ghost.
    eat_sel    = edible & (~edible + NG_ONE);
    tmr_dec    = (fright_tmr != '0) ? fright_tmr - TMR_ONE : '0;
    tmr_nxt    = power_pellet ? FRIGHT_LOAD : tmr_dec;
    fr_nxt     = (power_pellet ? '1 : ((tmr_dec == '0) ? '0 : frightened)) & ~eat_sel;
    warn_nxt   = (tmr_nxt != '0) && (tmr_nxt <= WARN_LVL);
    chain_base = power_pellet ? 2'd0 : chain;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state         <= PLAY;
      frightened    <= '0;
      fright_warn   <= 1'b0;
      ghost_respawn <= '0;
      score_add     <= '0;
      freeze        <= 1'b0;
      lives         <= LIVES_RST;
      game_over     <= 1'b0;
      fright_tmr    <= '0;
      death_cnt     <= '0;
      chain         <= 2'd0;
    end else begin
      ghost_respawn <= '0;
      score_add     <= '0;
      case (state)
        PLAY: begin
          if (|deadly) begin
            state       <= DYING;
            death_cnt   <= DEATH_LOAD;
            lives       <= lives - 2'd1;
            frightened  <= '0;
            fright_tmr  <= '0;
            fright_warn <= 1'b0;
            chain       <= 2'd0;
            freeze      <= 1'b1;
          end else begin
            fright_tmr  <= tmr_nxt;
            frightened  <= fr_nxt;
            fright_warn <= warn_nxt;
            if (|eat_sel) begin
              ghost_respawn <= eat_sel;
              score_add     <= ghost_score(chain_base);
              chain         <= (chain_base == 2'd3) ? 2'd3 : chain_base + 2'd1;
            end else begin
              chain <= chain_base;
            end
          end
        end
        DYING: begin
          death_cnt <= death_cnt - DCNT_ONE;
          if (death_cnt == DCNT_ONE) begin
            if (lives == 2'd0) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state         <= PLAY;
              freeze        <= 1'b0;
              ghost_respawn <= '1;
            end
          end
        end
        GAME_OVER: begin
          freeze    <= 1'b1;
          game_over <= 1'b1;
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Self-checking bench for ghost_collision_ctrl: directed scenarios plus a
// randomized run compared against a frame-numbered behavioural model.
module tb_ghost_collision_ctrl;

  localparam int NG = 4;
  localparam int FRF = 360;
  localparam int WRN = 120;
  localparam int DF = 120;

  logic             frame_clk;
  logic             Reset;
  logic [9:0]       pac_x, pac_y;
  logic [NG-1:0][9:0] ghost_x, ghost_y;
  logic             power_pellet;
  logic [NG-1:0]    frightened;
  logic             fright_warn;
  logic [NG-1:0]    ghost_respawn;
  logic [11:0]      score_add;
  logic             freeze;
  logic [1:0]       lives;
  logic             game_over;

  int checks = 0;
  int failures = 0;

  // Model: absolute frame numbers for fright end and dying end.
  int     m_e, m_fend, m_dend, m_chain, m_lives, m_mode, m_score;
  bit [3:0] m_fr, m_resp;

  ghost_collision_ctrl dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .pac_x         (pac_x),
    .pac_y         (pac_y),
    .ghost_x       (ghost_x),
    .ghost_y       (ghost_y),
    .power_pellet  (power_pellet),
    .frightened    (frightened),
    .fright_warn   (fright_warn),
    .ghost_respawn (ghost_respawn),
    .score_add     (score_add),
    .freeze        (freeze),
    .lives         (lives),
    .game_over     (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_e = 0; m_fend = 0; m_dend = 0; m_chain = 0; m_lives = 3; m_mode = 0;
    m_score = 0; m_fr = 4'h0; m_resp = 4'h0;
  endtask

  function automatic bit [3:0] model_overlap();
    bit [3:0] ov;
    ov = 4'h0;
    for (int i = 0; i < NG; i++) begin
      int dx;
      int dy;
      dx = int'(pac_x) - int'(ghost_x[i]);
      dy = int'(pac_y) - int'(ghost_y[i]);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      ov[i] = (dx < 12) && (dy < 12);
    end
    return ov;
  endfunction

  task automatic model_edge(input bit pel, input bit [3:0] ov);
    bit [3:0] fr;
    bit found;
    m_e++;
    m_resp = 4'h0;
    m_score = 0;
    if (m_mode == 0) begin
      fr = m_fr;
      if (pel) begin fr = 4'hF; m_fend = m_e + FRF; m_chain = 0; end
      if ((ov & ~fr) != 4'h0) begin
        m_mode = 1; m_dend = m_e + DF; m_lives--; m_fr = 4'h0; m_fend = m_e;
      end else begin
        found = 0;
        for (int i = 0; i < NG; i++)
          if (!found && ov[i] && fr[i]) begin
            found = 1; fr[i] = 0; m_resp[i] = 1;
            m_score = 200 * (1 << m_chain);
            if (m_chain < 3) m_chain++;
          end
        m_fr = (m_e >= m_fend) ? 4'h0 : fr;
      end
    end else if (m_mode == 1) begin
      if (m_e == m_dend) begin
        if (m_lives == 0) m_mode = 2;
        else begin m_mode = 0; m_resp = 4'hF; end
      end
    end
  endtask

  function automatic bit model_warn();
    return (m_mode == 0) && (m_fend - m_e >= 1) && (m_fend - m_e <= WRN);
  endfunction

  task automatic tick();
    bit [3:0] ov;
    bit pel;
    ov = model_overlap();
    pel = power_pellet;
    @(posedge frame_clk);
    model_edge(pel, ov);
    #1;
  endtask

  task automatic do_reset();
    #2 Reset = 1'b1;
    power_pellet = 1'b0;
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();
  endtask

  task automatic place_far(input int i);
    ghost_x[i] = 10'(100 + i * 200);
    ghost_y[i] = 10'd900;
  endtask

  task automatic place_on(input int i);
    ghost_x[i] = pac_x + 10'd3;
    ghost_y[i] = pac_y - 10'd2;
  endtask

  task automatic all_far();
    pac_x = 10'd300; pac_y = 10'd300;
    for (int i = 0; i < NG; i++) place_far(i);
  endtask

  task automatic test_reset();
    Reset = 1'b1; power_pellet = 1'b0; all_far();
    repeat (3) @(posedge frame_clk);
    #1;
    checks += 7;
    if (frightened !== 4'h0) begin failures++; $display("FAIL rst_frightened got=%b exp=0000", frightened); end
    if (fright_warn !== 1'b0) begin failures++; $display("FAIL rst_warn got=%b exp=0", fright_warn); end
    if (ghost_respawn !== 4'h0) begin failures++; $display("FAIL rst_respawn got=%b exp=0000", ghost_respawn); end
    if (score_add !== 12'd0) begin failures++; $display("FAIL rst_score got=%0d exp=0", score_add); end
    if (freeze !== 1'b0) begin failures++; $display("FAIL rst_freeze got=%b exp=0", freeze); end
    if (lives !== 2'd3) begin failures++; $display("FAIL rst_lives got=%0d exp=3", lives); end
    if (game_over !== 1'b0) begin failures++; $display("FAIL rst_game_over got=%b exp=0", game_over); end
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_fright_timer();
    int fr_cnt, warn_cnt, first_warn;
    fr_cnt = 0; warn_cnt = 0; first_warn = -1;
    all_far();
    power_pellet = 1'b1;
    tick();
    power_pellet = 1'b0;
    for (int k = 0; k < FRF; k++) begin
      if (frightened === 4'hF) fr_cnt++;
      if (fright_warn === 1'b1) begin
        warn_cnt++;
        if (first_warn < 0) first_warn = k;
      end
      tick();
    end
    checks += 5;
    if (fr_cnt !== FRF) begin failures++; $display("FAIL fright_len got=%0d exp=%0d", fr_cnt, FRF); end
    if (warn_cnt !== WRN) begin failures++; $display("FAIL warn_len got=%0d exp=%0d", warn_cnt, WRN); end
    if (first_warn !== FRF - WRN) begin failures++; $display("FAIL warn_start got=%0d exp=%0d", first_warn, FRF - WRN); end
    if (frightened !== 4'h0) begin failures++; $display("FAIL fright_end got=%b exp=0000", frightened); end
    if (fright_warn !== 1'b0) begin failures++; $display("FAIL warn_end got=%b exp=0", fright_warn); end
  endtask

  task automatic test_eat_chain();
    all_far();
    power_pellet = 1'b1; tick(); power_pellet = 1'b0;
    place_on(0); place_on(2); tick();
    checks += 3;
    if (ghost_respawn !== 4'b0001) begin failures++; $display("FAIL eat1_resp got=%b exp=0001", ghost_respawn); end
    if (score_add !== 12'd200) begin failures++; $display("FAIL eat1_score got=%0d exp=200", score_add); end
    if (frightened !== 4'b1110) begin failures++; $display("FAIL eat1_fright got=%b exp=1110", frightened); end
    place_far(0); tick();
    checks += 2;
    if (ghost_respawn !== 4'b0100) begin failures++; $display("FAIL eat2_resp got=%b exp=0100", ghost_respawn); end
    if (score_add !== 12'd400) begin failures++; $display("FAIL eat2_score got=%0d exp=400", score_add); end
    place_far(2); place_on(1); place_on(3); tick();
    checks += 2;
    if (ghost_respawn !== 4'b0010) begin failures++; $display("FAIL eat3_resp got=%b exp=0010", ghost_respawn); end
    if (score_add !== 12'd800) begin failures++; $display("FAIL eat3_score got=%0d exp=800", score_add); end
    place_far(1); tick();
    checks += 2;
    if (ghost_respawn !== 4'b1000) begin failures++; $display("FAIL eat4_resp got=%b exp=1000", ghost_respawn); end
    if (score_add !== 12'd1600) begin failures++; $display("FAIL eat4_score got=%0d exp=1600", score_add); end
    place_far(3); tick();
    checks += 2;
    if (ghost_respawn !== 4'b0000) begin failures++; $display("FAIL pulse_width_resp got=%b exp=0000", ghost_respawn); end
    if (score_add !== 12'd0) begin failures++; $display("FAIL pulse_width_score got=%0d exp=0", score_add); end
    // Ghost 0 is normal now; pellet in the same frame makes it edible.
    place_on(0); power_pellet = 1'b1; tick(); power_pellet = 1'b0;
    checks += 3;
    if (score_add !== 12'd200) begin failures++; $display("FAIL pellet_eat_score got=%0d exp=200", score_add); end
    if (ghost_respawn !== 4'b0001) begin failures++; $display("FAIL pellet_eat_resp got=%b exp=0001", ghost_respawn); end
    if (freeze !== 1'b0) begin failures++; $display("FAIL pellet_eat_freeze got=%b exp=0", freeze); end
    place_far(0);
  endtask

  task automatic test_boundary();
    do_reset(); all_far();
    ghost_x[0] = pac_x + 10'd12; ghost_y[0] = pac_y; tick();
    ghost_x[0] = pac_x; ghost_y[0] = pac_y - 10'd12; tick();
    pac_x = 10'd0; ghost_x[0] = 10'd1020; ghost_y[0] = pac_y; tick();
    checks++;
    if (freeze !== 1'b0) begin failures++; $display("FAIL dist12_or_wrap_freeze got=%b exp=0", freeze); end
    pac_x = 10'd300; ghost_x[0] = 10'd289; ghost_y[0] = 10'd311; tick();
    checks++;
    if (freeze !== 1'b1) begin failures++; $display("FAIL dist11_freeze got=%b exp=1", freeze); end
    do_reset(); all_far();
  endtask

  task automatic test_death();
    int bad;
    do_reset(); all_far();
    power_pellet = 1'b1; tick(); power_pellet = 1'b0;
    place_on(1); tick();
    place_on(0); tick();
    checks += 5;
    if (freeze !== 1'b1) begin failures++; $display("FAIL death_freeze got=%b exp=1", freeze); end
    if (lives !== 2'd2) begin failures++; $display("FAIL death_lives got=%0d exp=2", lives); end
    if (score_add !== 12'd0) begin failures++; $display("FAIL death_score got=%0d exp=0", score_add); end
    if (ghost_respawn !== 4'h0) begin failures++; $display("FAIL death_resp got=%b exp=0000", ghost_respawn); end
    if (frightened !== 4'h0) begin failures++; $display("FAIL death_fright got=%b exp=0000", frightened); end
    bad = 0;
    for (int k = 1; k < DF; k++) begin
      power_pellet = 1'($urandom_range(0, 1));
      tick();
      if (freeze !== 1'b1 || ghost_respawn !== 4'h0 || score_add !== 12'd0 || frightened !== 4'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL dying_hold bad_frames=%0d exp=0", bad); end
    power_pellet = 1'b0; all_far(); tick();
    checks += 4;
    if (ghost_respawn !== 4'hF) begin failures++; $display("FAIL revive_resp got=%b exp=1111", ghost_respawn); end
    if (freeze !== 1'b0) begin failures++; $display("FAIL revive_freeze got=%b exp=0", freeze); end
    if (lives !== 2'd2) begin failures++; $display("FAIL revive_lives got=%0d exp=2", lives); end
    if (frightened !== 4'h0) begin failures++; $display("FAIL revive_fright got=%b exp=0000", frightened); end
    tick();
    checks++;
    if (ghost_respawn !== 4'h0) begin failures++; $display("FAIL revive_pulse got=%b exp=0000", ghost_respawn); end
  endtask

  task automatic test_game_over();
    int bad;
    do_reset(); all_far();
    for (int d = 0; d < 3; d++) begin
      place_on(0); tick(); place_far(0);
      repeat (DF) tick();
    end
    checks += 4;
    if (game_over !== 1'b1) begin failures++; $display("FAIL go_flag got=%b exp=1", game_over); end
    if (freeze !== 1'b1) begin failures++; $display("FAIL go_freeze got=%b exp=1", freeze); end
    if (lives !== 2'd0) begin failures++; $display("FAIL go_lives got=%0d exp=0", lives); end
    if (ghost_respawn !== 4'h0) begin failures++; $display("FAIL go_resp got=%b exp=0000", ghost_respawn); end
    bad = 0;
    place_on(2);
    for (int k = 0; k < 30; k++) begin
      power_pellet = 1'($urandom_range(0, 1));
      tick();
      if (game_over !== 1'b1 || freeze !== 1'b1 || ghost_respawn !== 4'h0 || score_add !== 12'd0 || frightened !== 4'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL go_sticky bad_frames=%0d exp=0", bad); end
    do_reset(); all_far();
    checks += 2;
    if (game_over !== 1'b0) begin failures++; $display("FAIL go_clear got=%b exp=0", game_over); end
    if (lives !== 2'd3) begin failures++; $display("FAIL go_clear_lives got=%0d exp=3", lives); end
  endtask

  task automatic test_reset_mid_dying();
    int bad;
    do_reset(); all_far();
    place_on(0); tick(); place_far(0);
    repeat (50) tick();
    #2 Reset = 1'b1;
    #1;
    checks += 3;
    if (lives !== 2'd3) begin failures++; $display("FAIL midrst_lives got=%0d exp=3", lives); end
    if (freeze !== 1'b0) begin failures++; $display("FAIL midrst_freeze got=%b exp=0", freeze); end
    if (ghost_respawn !== 4'h0) begin failures++; $display("FAIL midrst_resp got=%b exp=0000", ghost_respawn); end
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    model_reset();
    bad = 0;
    repeat (DF + 10) begin
      tick();
      if (ghost_respawn !== 4'h0 || freeze !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL midrst_after bad_frames=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    do_reset(); all_far();
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 9))
        0: pac_x = 10'd0;
        1: pac_x = 10'd1023;
        default: pac_x = 10'($urandom_range(0, 1023));
      endcase
      pac_y = 10'($urandom_range(0, 1023));
      for (int i = 0; i < NG; i++) begin
        if ($urandom_range(0, 9) < 2) begin
          ghost_x[i] = pac_x + 10'($urandom_range(0, 30)) - 10'd15;
          ghost_y[i] = pac_y + 10'($urandom_range(0, 30)) - 10'd15;
        end else begin
          ghost_x[i] = 10'($urandom_range(0, 1023));
          ghost_y[i] = 10'($urandom_range(0, 1023));
        end
      end
      power_pellet = ($urandom_range(0, 99) < 6);
      tick();
      checks += 7;
      if (frightened !== m_fr) begin failures++; $display("FAIL rnd_fright cyc=%0d got=%b exp=%b", c, frightened, m_fr); end
      if (fright_warn !== model_warn()) begin failures++; $display("FAIL rnd_warn cyc=%0d got=%b exp=%b", c, fright_warn, model_warn()); end
      if (ghost_respawn !== m_resp) begin failures++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, ghost_respawn, m_resp); end
      if (int'(score_add) !== m_score) begin failures++; $display("FAIL rnd_score cyc=%0d got=%0d exp=%0d", c, score_add, m_score); end
      if (freeze !== (m_mode != 0)) begin failures++; $display("FAIL rnd_freeze cyc=%0d got=%b exp=%b", c, freeze, m_mode != 0); end
      if (int'(lives) !== m_lives) begin failures++; $display("FAIL rnd_lives cyc=%0d got=%0d exp=%0d", c, lives, m_lives); end
      if (game_over !== (m_mode == 2)) begin failures++; $display("FAIL rnd_go cyc=%0d got=%b exp=%b", c, game_over, m_mode == 2); end
      if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 999) == 0) do_reset();
    end
    power_pellet = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fright_timer();
    test_eat_chain();
    test_boundary();
    test_death();
    test_game_over();
    test_reset_mid_dying();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost_collision_ctrl.md
# ghost_collision_ctrl

Per-frame consumer of the ghost position/direction outputs and the Pac-Man position. Detects sprite overlap, runs the power-pellet frightened timer, and decides each outcome: ghost eaten (score plus respawn) or Pac-Man death (freeze, life lost, game over). It sits between the four ghost movers, the player mover and the score/HUD logic, and drives each ghost mover's reset as a respawn request.

## Interface
- NUM_GHOSTS, 4, number of ghost instances
- COLL_DIST, 12, overlap threshold in pixels, per axis
- FRIGHT_FRAMES, 360, frightened duration in frames
- WARN_FRAMES, 120, remaining frames at which fright_warn asserts
- DEATH_FRAMES, 120, freeze length after a death
- LIVES_INIT, 3, lives at reset
- frame_clk  in  1  frame clock; all logic on its rising edge
- Reset  in  1  asynchronous, active-high
- pac_x, pac_y  in  10 each  Pac-Man top-left pixel
- ghost_x, ghost_y  in  NUM_GHOSTS x 10  ghost top-left pixels
- power_pellet  in  1  one-frame pulse; pellet eaten
- frightened  out  NUM_GHOSTS  ghost i is edible
- fright_warn  out  1  fright timer is in its last WARN_FRAMES frames
- ghost_respawn  out  NUM_GHOSTS  one-frame pulse to ghost i reset
- score_add  out  12  points to add this frame, 0 otherwise
- freeze  out  1  halts all movers; high during DYING and GAME_OVER
- lives  out  2  remaining lives
- game_over  out  1  sticky until Reset

## Operation
- Overlap(i): |pac_x - ghost_x[i]| < COLL_DIST and |pac_y - ghost_y[i]| < COLL_DIST. Differences use 11-bit signed arithmetic; no wrap.
- FSM states: PLAY, DYING, GAME_OVER. Reset enters PLAY.
- Reset values: frightened 0, fright_warn 0, ghost_respawn 0, score_add 0, freeze 0, lives LIVES_INIT, game_over 0, fright timer 0, chain 0.
- PLAY, power_pellet: all frightened bits set, fright timer = FRIGHT_FRAMES, chain reset to 0. A pellet arriving during fright restarts the timer and re-frightens ghosts already eaten.
- PLAY, fright timer: decrements by 1 per frame while nonzero. On reaching 0, all frightened bits clear. fright_warn = (timer != 0 and timer <= WARN_FRAMES).
- PLAY, any overlap with a ghost whose frightened bit is 0: death wins over every eat in the same frame.
  - Go to DYING with death counter = DEATH_FRAMES.
  - lives decrements; frightened clears; timer clears; score_add = 0.
- PLAY, otherwise, overlap with a frightened ghost: only the lowest such index is eaten this frame. Others are handled in the next frame if they still overlap.
  - Clear that ghost's frightened bit and pulse its ghost_respawn.
  - score_add = 200 << chain, giving 200, 400, 800, 1600.
  - chain increments and saturates at 3.
- Pellet and collision in the same frame: the pellet is applied first, so any overlapped ghost is eaten, not deadly.
- DYING: freeze = 1; pellets and collisions are ignored. When the counter expires:
  - lives == 0: go to GAME_OVER.
  - otherwise: pulse all ghost_respawn bits and return to PLAY.
- GAME_OVER: freeze = 1, game_over = 1; all inputs ignored until Reset.
- Reset mid-fright or mid-DYING: immediate return to reset values. No respawn pulse is emitted.

## Timing
- All outputs are registered.
- Inputs sampled at edge N take effect on outputs immediately after edge N.
- score_add and ghost_respawn are exactly one frame wide.
- freeze rises on the same edge as the DYING entry.
- DYING lasts exactly DEATH_FRAMES frames. The respawn pulse coincides with the first PLAY frame, and freeze is 0 in that frame.
- The ghost movers see the respawn pulse as their Reset during the frame after it.
- Fright: with a pellet at edge N and no further pellets, frightened falls on edge N+FRIGHT_FRAMES.

## Structure
- Shared pacman_pkg holds:
  - the state enum (PLAY, DYING, GAME_OVER)
  - SPRITE_SIZE = 16
  - the ghost base score constant 200
  - the direction encoding 0 up, 1 left, 2 down, 3 right
- One sub-module, sprite_overlap: combinational per-ghost overlap compare, instantiated NUM_GHOSTS times.

## Test plan
- Pellet pulse, then no collision: frightened = 4'b1111 for 360 frames; fright_warn high for the last 120 frames; all bits clear on frame 360.
- Frightened ghosts 0 and 2 overlapping Pac-Man together:
  - frame 1: respawn 4'b0001, score_add 200
  - frame 2: respawn 4'b0100, score_add 400
- Four consecutive eats score 200, 400, 800, 1600. A fifth eat after a re-pellet scores 200.
- Non-frightened ghost 1 overlaps in the same frame as frightened ghost 0:
  - DYING, lives 3 → 2, score_add 0
  - after 120 frames: respawn = 4'b1111, freeze drops
- Three deaths from reset: game_over = 1 and freeze = 1 after the third DYING completes; stays set until Reset.
- Pellet and overlap with a normal ghost in the same frame: the ghost is eaten (score_add 200) with no death. Separately, Reset asserted mid-DYING returns lives to 3 and freeze to 0 with no respawn pulse.
